// File: rtl/shift_deser.sv
// Serial-in/parallel-out deserializer, MSB- or LSB-first, valid/ready on both sides.
// A completed word appears on data_out one cycle after its last bit; it is held until out_ready.
module shift_deser #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             left_right,
  input  logic             ser_valid,
  input  logic             ser_in,
  output logic             ser_ready,
  output logic [WIDTH-1:0] data_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, ACCUM, FULL} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic             valid_q, valid_d;

  logic             accept;
  logic             dir_use;
  logic             last_bit;
  logic [WIDTH-1:0] shifted;

  assign ser_ready = (state_q != FULL) || out_ready;
  assign accept    = ser_valid && ser_ready && !clear;
  // The first bit of a word arrives in IDLE or FULL; only then is left_right honoured.
  assign dir_use   = (state_q == ACCUM) ? dir_q : left_right;
  assign shifted   = dir_use ? {sreg_q[WIDTH-2:0], ser_in} : {ser_in, sreg_q[WIDTH-1:1]};
  assign last_bit  = (state_q == ACCUM) && (cnt_q == CW'(WIDTH-1));

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    valid_d = valid_q;
    if (clear) begin
      state_d = IDLE;
      sreg_d  = '0;
      cnt_d   = '0;
      valid_d = 1'b0;
    end else begin
      if (state_q == FULL && out_ready) begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
      if (accept) begin
        sreg_d = shifted;
        dir_d  = dir_use;
        if (last_bit) begin
          state_d = FULL;
          cnt_d   = '0;
          data_d  = shifted;
          valid_d = 1'b1;
        end else begin
          state_d = ACCUM;
          cnt_d   = cnt_q + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      valid_q <= valid_d;
    end
  end

  assign data_out  = data_q;
  assign out_valid = valid_q;
  assign busy      = (state_q == ACCUM);

endmodule

// File: tb/tb_shift_deser.sv
// Scoreboard bench for shift_deser: directed scenarios plus randomized traffic.
module tb_shift_deser;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, clear, left_right, ser_valid, ser_in, out_ready;
  logic         ser_ready, out_valid, busy;
  logic [W-1:0] data_out;

  shift_deser #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .clear(clear), .left_right(left_right),
    .ser_valid(ser_valid), .ser_in(ser_in), .ser_ready(ser_ready),
    .data_out(data_out), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int tests = 0, failed = 0, cyc_n = 0;
  always @(posedge clk) cyc_n++;

  // Reference model: bits of the word in progress, latched direction, held-word flag.
  int           bits[$];
  bit           mdir, mfull, cur_full, shown;
  logic [W-1:0] expq[$];
  logic [W-1:0] last_word, hold;
  int           pulses[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    tests++;
    if (act !== exp_v) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp_v, $time);
    end
  endtask

  task automatic model_step(input logic sv, b, lr, ordy, clr);
    int v;
    bit acc;
    if (clr) begin
      bits.delete();
      mfull = 0;
      return;
    end
    acc = sv && (!mfull || ordy);
    if (mfull && ordy) mfull = 0;
    if (acc) begin
      if (bits.size() == 0) mdir = lr;
      bits.push_back(int'(b));
      if (bits.size() == W) begin
        v = 0;
        for (int i = 0; i < W; i++) v += bits[i] << (mdir ? (W - 1 - i) : i);
        expq.push_back(v[W-1:0]);
        bits.delete();
        mfull = 1;
      end
    end
  endtask

  task automatic cyc(input logic sv, b, lr, ordy, clr);
    @(posedge clk);
    #1;
    ser_valid = sv; ser_in = b; left_right = lr; out_ready = ordy; clear = clr;
    #1;
    chk("ser_ready", ser_ready, !mfull || ordy);
    chk("busy", busy, bits.size() > 0);
    cur_full = mfull;
    model_step(sv, b, lr, ordy, clr);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic send_word(input logic [W-1:0] val, input logic lr, input logic ordy);
    for (int i = 0; i < W; i++) cyc(1'b1, lr ? val[W-1-i] : val[i], lr, ordy, 1'b0);
  endtask

  task automatic model_reset();
    bits.delete();
    expq.delete();
    mfull = 0;
    cur_full = 0;
    shown = 0;
  endtask

  // Monitor: pops the scoreboard when a new word appears, then checks it stays stable.
  initial begin
    forever begin
      @(posedge clk);
      #3;
      if (!rst) begin
        chk("out_valid", out_valid, cur_full);
        if (out_valid) begin
          if (!shown) begin
            if (expq.size() == 0) begin
              tests++; failed++;
              $display("FAIL unexpected_word: got %0h expected none", data_out);
            end else begin
              chk("data_out", data_out, expq.pop_front());
            end
            last_word = data_out;
            pulses.push_back(cyc_n);
            shown = 1;
            hold = data_out;
          end else begin
            chk("held_data", data_out, hold);
          end
        end
        if (out_ready || clear) shown = 0;
      end
    end
  end

  logic [W-1:0] lsb_bits;

  initial begin
    rst = 1; clear = 0; left_right = 1; ser_valid = 0; ser_in = 0; out_ready = 1;
    model_reset();
    #12;
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_data", data_out, 0);
    rst = 0;

    // MSB-first 1,0,1,1,0,0,1,0
    send_word(8'hB2, 1'b1, 1'b1);
    idle(2);
    chk("msb_word", last_word, 8'hB2);

    // Same bit order on the wire, LSB-first interpretation
    lsb_bits = 8'h4D;
    send_word(lsb_bits, 1'b0, 1'b1);
    idle(2);
    chk("lsb_word", last_word, 8'h4D);

    // Direction changed after bit 3 is ignored until the next word
    for (int i = 0; i < W; i++) cyc(1'b1, lsb_bits[W-1-i] ^ 1'b0 ? 1'b0 : 1'b0, 1'b1, 1'b1, 1'b0);
    idle(2);
    chk("zero_word", last_word, 8'h00);
    begin
      logic [W-1:0] t;
      t = 8'hB2;
      for (int i = 0; i < W; i++) cyc(1'b1, t[W-1-i], (i < 3), 1'b1, 1'b0);
    end
    idle(2);
    chk("toggle_word", last_word, 8'hB2);
    send_word(8'h4D, 1'b0, 1'b1);
    idle(2);
    chk("next_dir_word", last_word, 8'h4D);

    // Stall while full: bits refused and data held, then release accepts bit 1
    send_word(8'h5A, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b0);
      chk("stall_ready", ser_ready, 0);
    end
    chk("stall_hold", data_out, 8'h5A);
    send_word(8'hC3, 1'b1, 1'b1);
    idle(2);
    chk("after_stall", last_word, 8'hC3);

    // Back-to-back stream
    pulses.delete();
    send_word(8'hA5, 1'b1, 1'b1);
    send_word(8'h3C, 1'b1, 1'b1);
    send_word(8'hFF, 1'b1, 1'b1);
    idle(2);
    chk("stream_count", pulses.size(), 3);
    if (pulses.size() == 3) begin
      chk("stream_gap1", pulses[1] - pulses[0], 8);
      chk("stream_gap2", pulses[2] - pulses[1], 8);
    end
    chk("stream_last", last_word, 8'hFF);

    // Asynchronous reset mid-word
    send_word(8'hF0, 1'b1, 1'b1);
    idle(2);
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    #2 rst = 1;
    #2;
    chk("arst_valid", out_valid, 0);
    chk("arst_busy", busy, 0);
    @(posedge clk);
    #2 rst = 0;
    model_reset();
    send_word(8'h81, 1'b1, 1'b1);
    idle(2);
    chk("post_rst_word", last_word, 8'h81);

    // Synchronous clear after 5 bits; the bit offered with clear is dropped
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    idle(1);
    chk("clr_busy", busy, 0);
    chk("clr_valid", out_valid, 0);
    send_word(8'h81, 1'b1, 1'b1);
    idle(2);
    chk("post_clr_word", last_word, 8'h81);

    // Randomized traffic
    for (int n = 0; n < 3000; n++)
      cyc(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          ($urandom_range(0, 9) < 7), ($urandom_range(0, 63) == 0));
    idle(4);
    chk("scoreboard_empty", expq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
